// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
// Row-scanning controller for a 4x4 active-low matrix keypad. Drives one row
// low at a time, samples the columns after a settle dwell, debounces press and
// release with a shared counter, and emits one key_valid pulse per press.
// While a key is held the row is frozen on it and every other key is locked out.

module keypad_scan_controller #(
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_CYCLES = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] SETTLE_LAST   = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO      = CW'(0);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    r_q, r_d;
    logic [1:0]    c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    rows_q, rows_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic [2:0]    col_hit_s;

    // Single-low-column decode: {valid, index}. Zero or several lows (ghosting) give valid=0.
    function automatic logic [2:0] decode_col(input logic [3:0] c);
        logic [2:0] res;
        case (c)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Key legend for (row, col); col 0 is the leftmost column.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Next-state logic for the scan/debounce FSM and its registered outputs.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        col_hit_s   = decode_col(cols);

        case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    if (col_hit_s[2]) begin
                        c_d     = col_hit_s[1:0];
                        cnt_d   = CNT_ZERO;
                        state_d = DB_PRESS;
                    end else begin
                        r_d   = r_q + 2'd1;
                        cnt_d = CNT_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_PRESS: begin
                if (cols[c_q]) begin
                    // Column bounced back high before the debounce window closed.
                    r_d     = r_q + 2'd1;
                    cnt_d   = CNT_ZERO;
                    state_d = SCAN;
                end else if (cnt_q == DEBOUNCE_LAST) begin
                    key_valid_d = 1'b1;
                    key_code_d  = key_map(r_q, c_q);
                    cnt_d       = CNT_ZERO;
                    state_d     = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (cols[c_q]) begin
                    cnt_d   = CNT_ZERO;
                    state_d = DB_RELEASE;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            DB_RELEASE: begin
                if (!cols[c_q]) begin
                    // Release bounce: the key is still considered held.
                    cnt_d   = CNT_ZERO;
                    state_d = HELD;
                end else if (cnt_q == DEBOUNCE_LAST) begin
                    r_d     = r_q + 2'd1;
                    cnt_d   = CNT_ZERO;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = SCAN;
                r_d     = 2'd0;
                cnt_d   = CNT_ZERO;
            end
        endcase

        rows_d     = ~(4'b0001 << r_d);
        key_held_d = (state_d == HELD) || (state_d == DB_RELEASE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            cnt_q       <= CNT_ZERO;
            rows_q      <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            rows_q      <= rows_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign rows      = rows_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller
// Drives the controller from a behavioural 4x4 keypad (pressed-key matrix
// resolved against the active row). Expected key codes are queued when a press
// is staged and compared whenever the controller pulses key_valid.

module tb_keypad_scan_controller;

    localparam int S = 2;
    localparam int D = 48;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = 16'h0000;   // bit r*4+c
    logic        cols_force_en = 1'b1;
    logic [3:0]  cols_force = 4'b0000;

    logic [3:0]  exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          last_pulse_cyc = 0;
    int          row_change_cyc = 0;
    logic [3:0]  rows_prev = 4'b1111;

    keypad_scan_controller #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Cycle counter (number of rising edges so far).
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: a column reads low when a pressed key sits on a driven row.
    always_comb begin
        logic [3:0] low;
        low = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rows[r] && pressed[r*4+c]) low[c] = 1'b1;
            end
        end
        cols = cols_force_en ? cols_force : ~low;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard pop on each pulse, row-change timestamping.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt      <= pulse_cnt + 1;
            last_pulse_cyc <= cyc;
            if (exp_q.size() > 0) check_eq("key_code", key_code, exp_q.pop_front());
            else                  check_eq("spurious_pulse", key_valid, 1'b0);
        end
        if (rows !== rows_prev) row_change_cyc <= cyc;
        rows_prev <= rows;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input int budget);
        int start;
        start = pulse_cnt;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (pulse_cnt != start) break;
        end
        check_eq("pulse_seen", pulse_cnt, start + 1);
    endtask

    task automatic wait_held_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (key_held === 1'b0) break;
        end
        check_eq("held_fall_seen", key_held, 1'b0);
    endtask

    initial begin
        int rel_cyc;
        int pc;
        logic [3:0] exp_rows;

        // Reset with all columns low.
        repeat (3) tick();
        check_eq("rst_rows", rows, 4'b1110);
        check_eq("rst_code", key_code, 4'h0);
        check_eq("rst_valid", key_valid, 1'b0);
        check_eq("rst_held", key_held, 1'b0);
        cols_force_en = 1'b0;
        tick();
        reset = 1'b0;

        // Idle scan and wrap; the reset cycle counts toward row0's dwell.
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_rows = ~(4'b0001 << (((k + 1) >> 1) & 3));
            check_eq("idle_rows", rows, exp_rows);
        end

        // Single press of "5" (row1, col1).
        set_key(1, 1, 1'b1);
        exp_q.push_back(4'h5);
        do_reset(2);
        wait_pulse(200);
        check_eq("press_latency", last_pulse_cyc - row_change_cyc, S + D);
        check_eq("held_after_accept", key_held, 1'b1);
        tick();
        check_eq("valid_one_cycle", key_valid, 1'b0);
        repeat (100) tick();
        set_key(1, 1, 1'b0);
        rel_cyc = cyc;
        wait_held_low(200);
        check_eq("release_latency", cyc - rel_cyc, D + 1);
        check_eq("rows_after_release", rows, 4'b1011);
        check_eq("code_held", key_code, 4'h5);

        // Press bounce on "9" (row2, col2): aborts after 10 debounce cycles.
        do_reset(2);
        set_key(2, 2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (rows === 4'b1011) break;
            tick();
        end
        check_eq("bounce_row_found", rows, 4'b1011);
        repeat (12) tick();
        set_key(2, 2, 1'b0);
        tick();
        check_eq("bounce_rows_adv", rows, 4'b0111);
        check_eq("bounce_held", key_held, 1'b0);
        repeat (2) tick();
        check_eq("bounce_scan_wrap", rows, 4'b1110);

        // Ghosting: two keys on row0 are not captured, scanning moves on.
        set_key(0, 1, 1'b1);
        set_key(0, 2, 1'b1);
        do_reset(2);
        repeat (2) tick();
        check_eq("ghost_rows", rows, 4'b1101);
        repeat (20) tick();
        check_eq("ghost_held", key_held, 1'b0);
        set_key(0, 1, 1'b0);
        set_key(0, 2, 1'b0);

        // Lockout: hold "1", add "D", glitch "1", then release "1".
        set_key(0, 0, 1'b1);
        exp_q.push_back(4'h1);
        do_reset(2);
        wait_pulse(200);
        pc = pulse_cnt;
        set_key(3, 3, 1'b1);
        repeat (20) tick();
        check_eq("lockout_no_pulse", pulse_cnt, pc);
        set_key(0, 0, 1'b0);
        repeat (5) tick();
        check_eq("glitch_held", key_held, 1'b1);
        set_key(0, 0, 1'b1);
        repeat (10) tick();
        check_eq("glitch_back_held", key_held, 1'b1);
        check_eq("glitch_no_pulse", pulse_cnt, pc);
        set_key(0, 0, 1'b0);
        exp_q.push_back(4'hD);
        wait_pulse(400);
        set_key(3, 3, 1'b0);
        wait_held_low(200);

        // Reset during DB_PRESS at counter 30.
        set_key(0, 0, 1'b1);
        do_reset(2);
        repeat (32) tick();
        check_eq("dbp_held", key_held, 1'b0);
        check_eq("dbp_valid", key_valid, 1'b0);
        reset = 1'b1;
        set_key(0, 0, 1'b0);
        tick();
        check_eq("rst_dbp_rows", rows, 4'b1110);
        check_eq("rst_dbp_held", key_held, 1'b0);
        check_eq("rst_dbp_valid", key_valid, 1'b0);
        tick();
        reset = 1'b0;
        repeat (60) tick();

        // Reset during HELD.
        set_key(0, 0, 1'b1);
        exp_q.push_back(4'h1);
        do_reset(2);
        wait_pulse(200);
        repeat (5) tick();
        reset = 1'b1;
        set_key(0, 0, 1'b0);
        tick();
        check_eq("rst_held_rows", rows, 4'b1110);
        check_eq("rst_held_held", key_held, 1'b0);
        check_eq("rst_held_code", key_code, 4'h0);
        tick();
        reset = 1'b0;
        repeat (60) tick();

        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("pulse_total", pulse_cnt, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
